mux_arb_reg_n: RTL and testbench
================================

// Module: mux_arb_reg_n
// PURPOSE
//   N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
//   Successor to the combinational 4:1 datapath mux: adds parameterised width and
//   channel count, round-robin or fixed-select mode, and a one-entry output register.
//   Used where several producers (e.g. writeback sources, debug taps) share one
//   pipelined consumer port.
// PARAMETERS
//   WIDTH  32  data width per channel, >=1
//   N      4   channel count, 2..16
//   SEL_W  2   select/source-index width, = clog2(N)
// PORTS
//   clk        in   1        rising-edge clock, single domain
//   reset      in   1        asynchronous, active-high reset
//   mode       in   1        0 = fixed select by sel; 1 = round-robin over all channels
//   sel        in   SEL_W    channel index used when mode=0
//   in_valid   in   N        per-channel data valid
//   in_data    in   N*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   in_ready   out  N        per-channel accept; at most one bit high per cycle
//   out_valid  out  1        output register holds a word
//   out_data   out  WIDTH    registered data
//   out_src    out  SEL_W    index of the channel that supplied out_data
//   out_ready  in   1        consumer accept
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0,
//     rr_ptr=0. in_ready is combinational and therefore 0 while reset is high.
//   - load_en = !out_valid || out_ready. The output register loads only when load_en=1.
//   - Grant (combinational; valid only when load_en=1):
//       mode=0: grant=sel if sel<N and in_valid[sel]; otherwise no grant.
//       mode=1: first k with in_valid[k]=1, searching from rr_ptr upward modulo N.
//   - in_ready[g]=1 only for the granted g. Transfer in = in_valid[g] && in_ready[g].
//   - On transfer in, next edge: out_data<=in_data[g], out_src<=g, out_valid<=1.
//     In mode=1 only, rr_ptr<=(g+1) mod N, wrapping N-1 -> 0.
//     Mode=0 leaves rr_ptr unchanged.
//   - If out_valid && out_ready and there is no transfer in: out_valid<=0.
//     out_data and out_src hold their values.
//   - Simultaneous out-drain and in-load in the same cycle: the new word replaces
//     the old one; out_valid stays 1 (full throughput, 1 word/cycle).
//   - Latency: one cycle from input transfer to out_valid.
//   - Full (out_valid && !out_ready): all in_ready=0. out_data and out_src are stable.
//   - Empty with no in_valid eligible: out_valid falls or stays 0. rr_ptr unchanged.
//   - mode and sel are sampled only in load cycles. Changing them does not disturb a
//     held output word.
//   - Reset asserted mid-transfer: the word is dropped, outputs go to reset values
//     immediately, and rr_ptr returns to 0.
//   - sel>=N (only possible when N is not a power of 2): never grants, never errors.
// STRUCTURE
//   - Shared header mux_arb_defs.vh: MODE_FIXED=1'b0, MODE_RR=1'b1.
//   - Sub-module rr_grant_n #(N,SEL_W): inputs req[N], ptr; outputs gnt_valid, gnt_idx.
//     It is purely combinational, with a rotate / priority-encode / unrotate structure.
//   - Top level holds rr_ptr, the output register, the mode/sel mux and in_data slicing.
// TESTING
//   1 Reset: hold reset with in_valid=4'hF -> out_valid=0, out_data=0, in_ready=0.
//     Release: first grant is channel 0.
//   2 RR, WIDTH=32 N=4, all valid, out_ready=1, data k=32'h1000_000k
//     -> out_src sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
//   3 Backpressure: out_ready=0 with word 32'hDEAD_BEEF held 5 cycles -> in_ready=0,
//     out_data stable. out_ready=1 -> next word loads in the same cycle.
//   4 Fixed mode: mode=0, sel=2, in_valid=4'b0101 -> in_ready=4'b0100, out_src=2.
//     sel=1 with in_valid[1]=0 -> no grant, out_valid drops after drain.
//   5 Sparse RR wrap: rr_ptr=3, in_valid=4'b0011 -> grant 0, then rr_ptr=1 -> grant 1.
//   6 Async reset pulse mid-stream between clock edges -> out_valid falls before the
//     next edge. After release, rr_ptr=0 and the sequence restarts at channel 0.

Source files
------------

// File: rtl/mux_arb_reg_n_pkg.sv
// Shared definitions for the registered N-channel arbitrating mux.
// Exports the mode encoding used on the top-level 'mode' port.
package mux_arb_reg_n_pkg;

    // Select policy: fixed channel via 'sel' or round-robin over all channels.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage : mux_arb_reg_n_pkg

// File: rtl/rr_grant_n.sv
// Round-robin grant: picks the first asserted request at or above ptr, wrapping mod N.
// Purely combinational (rotate by ptr, priority-encode lowest bit, unrotate).
// Ports:
//   req       in  N       request vector
//   ptr       in  SEL_W   search start index, always < N
//   gnt_valid out 1       at least one request asserted
//   gnt_idx   out SEL_W   granted channel index (0 when gnt_valid=0)
module rr_grant_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;
    int unsigned      src;
    int unsigned      sum;

    // Rotate so that bit 0 of rot corresponds to channel ptr.
    always_comb begin
        rot = '0;
        src = 0;
        for (int unsigned i = 0; i < N; i++) begin
            src = int'(ptr) + i;
            if (src >= N) src = src - N;
            rot[i] = req[SEL_W'(src)];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        gnt_valid = 1'b0;
        off       = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_valid = 1'b1;
                off       = SEL_W'(i);
            end
        end
    end

    // Map the rotated offset back to an absolute channel index.
    always_comb begin
        sum = int'(ptr) + int'(off);
        if (sum >= N) sum = sum - N;
        gnt_idx = gnt_valid ? SEL_W'(sum) : '0;
    end

endmodule : rr_grant_n

// File: rtl/mux_arb_reg_n.sv
// N-channel WIDTH-bit registered mux with valid/ready on every channel and on the output.
// Fixed-select or round-robin arbitration feeds a one-entry output register that
// sustains one word per cycle when the consumer is ready.
// Ports:
//   clk, reset (async, active-high)
//   mode     in  1         0 = fixed via sel, 1 = round-robin
//   sel      in  SEL_W     fixed-mode channel index
//   in_valid in  N         per-channel valid
//   in_data  in  N*WIDTH   channel k at [k*WIDTH +: WIDTH]
//   in_ready out N         one-hot (or zero) combinational accept
//   out_valid/out_data/out_src  registered output word and its source channel
//   out_ready in 1         consumer accept
module mux_arb_reg_n
    import mux_arb_reg_n_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_src,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             fix_valid;
    logic             load_en_c;
    logic             gnt_valid_c;
    logic [SEL_W-1:0] gnt_idx_c;
    logic [WIDTH-1:0] gnt_data_c;

    rr_grant_n #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_grant (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Fixed-mode eligibility; a sel value >= N matches no channel and never grants.
    always_comb begin
        fix_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) fix_valid = 1'b1;
        end
    end

    // Grant only when the output register can accept and reset is released.
    assign load_en_c   = !out_valid || out_ready;
    assign gnt_idx_c   = (mode == MODE_RR) ? rr_idx : sel;
    assign gnt_valid_c = load_en_c && !reset &&
                         ((mode == MODE_RR) ? rr_valid : fix_valid);

    // One-hot ready and data select for the granted channel.
    always_comb begin
        in_ready   = '0;
        gnt_data_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt_idx_c == SEL_W'(k)) begin
                in_ready[k] = gnt_valid_c;
                gnt_data_c  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (gnt_valid_c) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data_c;
            out_src   <= gnt_idx_c;
            if (mode == MODE_RR) begin
                rr_ptr <= (int'(gnt_idx_c) == int'(N) - 1) ? '0 : gnt_idx_c + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : mux_arb_reg_n

// File: tb/tb_mux_arb_reg_n.sv
// Scoreboard bench for mux_arb_reg_n (WIDTH=32, N=4).
module tb_mux_arb_reg_n;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             mode;
    logic [SW-1:0]    sel;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_src;
    logic             out_ready;

    logic [SW+W-1:0]  exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    mux_arb_reg_n #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    task automatic default_data();
        for (int k = 0; k < int'(N); k++) set_ch(k, 32'h1000_0000 + W'(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word the consumer accepts must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {30'b0, out_src, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("out_word", {30'b0, out_src, out_data}, {30'b0, exp_q.pop_front()});
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with all channels valid
        reset = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = '0;
        default_data();
        #1;
        chk("rst_in_ready_async", 64'(in_ready), 64'h0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_src", 64'(out_src), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        step();
        reset = 1'b0;

        // 2: round-robin, all valid, five back-to-back grants 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (i % 4)));
            exp_q.push_back({SW'(i % 4), 32'h1000_0000 + W'(i % 4)});
            if (i > 0) chk("rr_no_bubble", 64'(out_valid), 64'h1);
        end
        step();

        // 3: backpressure on a held DEAD_BEEF word
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; set_ch(1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("bp_load_ready", 64'(in_ready), 64'h2);
        exp_q.push_back({2'd1, 32'hDEAD_BEEF});
        step();
        out_ready = 1'b0; set_ch(1, 32'h1111_1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'h0);
            chk("bp_out_data", 64'(out_data), 64'hDEAD_BEEF);
            chk("bp_out_valid", 64'(out_valid), 64'h1);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'h2);
        exp_q.push_back({2'd1, 32'h1111_1111});
        step();

        // 4: fixed mode sel=2 with in_valid=0101, then sel=1 on an idle channel
        sel = 2'd2; in_valid = 4'b0101; set_ch(2, 32'h2222_2222);
        @(negedge clk);
        chk("fix_in_ready", 64'(in_ready), 64'h4);
        exp_q.push_back({2'd2, 32'h2222_2222});
        step();
        sel = 2'd1;
        @(negedge clk);
        chk("fix_nogrant_ready", 64'(in_ready), 64'h0);
        step();
        @(negedge clk);
        chk("fix_drain_valid", 64'(out_valid), 64'h0);
        chk("fix_drain_ready", 64'(in_ready), 64'h0);
        step();

        // 5: sparse RR wrap; pointer is still 1, grant 2 moves it to 3
        mode = 1'b1; in_valid = 4'b0100; set_ch(2, 32'h3333_3333);
        @(negedge clk);
        chk("wrap_pre_ready", 64'(in_ready), 64'h4);
        exp_q.push_back({2'd2, 32'h3333_3333});
        step();
        in_valid = 4'b0011; set_ch(0, 32'h4444_4444); set_ch(1, 32'h5555_5555);
        @(negedge clk);
        chk("wrap_grant0", 64'(in_ready), 64'h1);
        exp_q.push_back({2'd0, 32'h4444_4444});
        @(negedge clk);
        chk("wrap_grant1", 64'(in_ready), 64'h2);
        exp_q.push_back({2'd1, 32'h5555_5555});
        step();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("wrap_idle_ready", 64'(in_ready), 64'h0);
        step();

        // 6: async reset pulse between edges while a word is held
        default_data(); in_valid = 4'hF;
        @(negedge clk);
        chk("ar_pre_ready", 64'(in_ready), 64'h4);
        exp_q.push_back({2'd2, 32'h1000_0002});
        step();
        #1;
        chk("ar_held_valid", 64'(out_valid), 64'h1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("ar_valid_fall", 64'(out_valid), 64'h0);
        chk("ar_data_clear", 64'(out_data), 64'h0);
        chk("ar_ready_zero", 64'(in_ready), 64'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_restart_ready", 64'(in_ready), 64'(4'b0001 << i));
            exp_q.push_back({SW'(i), 32'h1000_0000 + W'(i)});
        end
        step();
        in_valid = 4'b0000;
        repeat (3) step();
        @(negedge clk);
        chk("final_idle_valid", 64'(out_valid), 64'h0);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_arb_reg_n
